// File: rtl/sat_pkg.sv
// Shared SAT-cluster constants and width helpers.
// No logic; request-type encoding is common to all variable table clients.
// Backpressure: not applicable.
package sat_pkg;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first set request at or above ptr_i, wrapping to 0.
// Purely combinational, zero latency.
// Backpressure: none; any_o is low when no request is set.
module rr_priority_picker
    import sat_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int   cand;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr_i) + k) % N;
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = IW'(cand);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/vt_port_arbiter.sv
// Arbitrates NSAT solver cores onto the single variable table RAM port.
// Grant and RAM command in the accept cycle; read response one cycle later.
// Backpressure: one-hot req_ready_o; pause_i or an idle lock owner stalls every core.
module vt_port_arbiter
    import sat_pkg::*;
#(
    parameter int NSAT                   = 3,
    parameter int NUM_VARIABLES          = 16,
    parameter int VARIABLE_ADDRESS_WIDTH = $clog2(NUM_VARIABLES),
    parameter int DATA_WIDTH             = 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 pause_i,
    input  logic [NSAT-1:0]                      req_valid_i,
    input  logic [NSAT-1:0]                      req_we_i,
    input  logic [NSAT-1:0]                      req_lock_i,
    input  logic [NSAT*VARIABLE_ADDRESS_WIDTH-1:0] req_addr_i,
    input  logic [NSAT*DATA_WIDTH-1:0]           req_wdata_i,
    output logic [NSAT-1:0]                      req_ready_o,
    output logic [NSAT-1:0]                      rsp_valid_o,
    output logic [DATA_WIDTH-1:0]                rsp_data_o,
    output logic                                 vt_en_o,
    output logic                                 vt_we_o,
    output logic [VARIABLE_ADDRESS_WIDTH-1:0]    vt_addr_o,
    output logic [DATA_WIDTH-1:0]                vt_wdata_o,
    input  logic [DATA_WIDTH-1:0]                vt_rdata_i,
    output logic                                 busy_o
);

    localparam int AW = VARIABLE_ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int IW = idx_width(NSAT);

    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   own_q, own_d;
    logic [IW-1:0]   rsp_core_q, rsp_core_d;
    logic            lock_q, lock_d;
    logic            pend_q, pend_d;

    logic [NSAT-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [NSAT-1:0] gnt;
    logic [IW-1:0]   win;
    logic            accept;

    rr_priority_picker #(
        .N  (NSAT),
        .IW (IW)
    ) u_picker (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // A held lock blocks round-robin entirely, even while its owner is idle.
    always_comb begin
        gnt = '0;
        win = '0;
        if (!pause_i) begin
            if (lock_q) begin
                if (req_valid_i[own_q]) begin
                    gnt[own_q] = 1'b1;
                    win        = own_q;
                end
            end else if (pick_any) begin
                gnt = pick_gnt;
                win = pick_idx;
            end
        end
        accept = |gnt;
    end

    always_comb begin
        vt_en_o    = accept;
        vt_we_o    = accept & req_we_i[win];
        vt_addr_o  = accept ? req_addr_i[int'(win)*AW +: AW] : '0;
        vt_wdata_o = accept ? req_wdata_i[int'(win)*DW +: DW] : '0;
    end

    always_comb begin
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        own_d      = own_q;
        rsp_core_d = rsp_core_q;
        pend_d     = 1'b0;
        if (accept) begin
            ptr_d      = (int'(win) == NSAT - 1) ? '0 : win + IW'(1);
            lock_d     = req_lock_i[win];
            own_d      = win;
            rsp_core_d = win;
            pend_d     = (req_we_i[win] == REQ_READ);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            own_q      <= '0;
            rsp_core_q <= '0;
            lock_q     <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            own_q      <= own_d;
            rsp_core_q <= rsp_core_d;
            lock_q     <= lock_d;
            pend_q     <= pend_d;
        end
    end

    // Reset in the response cycle suppresses the in-flight read.
    always_comb begin
        rsp_valid_o = '0;
        rsp_data_o  = '0;
        if (pend_q && !rst_i) begin
            rsp_valid_o[rsp_core_q] = 1'b1;
            rsp_data_o              = vt_rdata_i;
        end
    end

    assign req_ready_o = gnt;
    assign busy_o      = pend_q | lock_q;

endmodule

// File: tb/tb_vt_port_arbiter.sv
// Bench for vt_port_arbiter: directed scenarios plus random traffic against a reference model.
module tb_vt_port_arbiter;

    localparam int N     = 3;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_i, pause_i;
    logic [N-1:0]    req_valid_i, req_we_i, req_lock_i;
    logic [N*AW-1:0] req_addr_i;
    logic [N-1:0]    req_wdata_i;
    logic [N-1:0]    req_ready_o, rsp_valid_o;
    logic            rsp_data_o;
    logic            vt_en_o, vt_we_o;
    logic [AW-1:0]   vt_addr_o;
    logic            vt_wdata_o;
    logic            vt_rdata_i;
    logic            busy_o;

    vt_port_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .pause_i     (pause_i),
        .req_valid_i (req_valid_i),
        .req_we_i    (req_we_i),
        .req_lock_i  (req_lock_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .vt_en_o     (vt_en_o),
        .vt_we_o     (vt_we_o),
        .vt_addr_o   (vt_addr_o),
        .vt_wdata_o  (vt_wdata_o),
        .vt_rdata_i  (vt_rdata_i),
        .busy_o      (busy_o)
    );

    // Variable table RAM: registered read, writes visible to later reads.
    logic [DEPTH-1:0] mem;
    logic [DEPTH-1:0] ram_seed;
    logic             ram_load;
    always @(posedge clk) begin
        if (ram_load) mem <= ram_seed;
        else if (vt_en_o) begin
            if (vt_we_o) mem[vt_addr_o] <= vt_wdata_o;
            else         vt_rdata_i     <= mem[vt_addr_o];
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DEPTH-1:0] ref_mem;
    int   m_ptr, m_own, m_pend;
    bit   m_lock;
    logic m_pdata;

    // Stimulus for the next cycle
    logic [N-1:0] v, we, lk;
    logic [AW-1:0] ad [N];
    logic wd [N];

    logic [N-1:0] last_gnt, last_rvld;
    logic         last_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        v = '0; we = '0; lk = '0;
        pause_i = 1'b0; rst_i = 1'b0;
        for (int i = 0; i < N; i++) begin ad[i] = '0; wd[i] = 1'b0; end
    endtask

    task automatic cyc();
        int g;
        logic [N-1:0] eg, erv;
        logic erd, ewe, ewd, ebusy;
        logic [AW-1:0] ead;
        req_valid_i = v; req_we_i = we; req_lock_i = lk;
        for (int i = 0; i < N; i++) begin
            req_addr_i[i*AW +: AW] = ad[i];
            req_wdata_i[i]         = wd[i];
        end
        #2;
        g = -1;
        if (!pause_i) begin
            if (m_lock) begin
                if (v[m_own]) g = m_own;
            end else begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        eg = '0; ewe = 1'b0; ead = '0; ewd = 1'b0;
        if (g >= 0) begin eg[g] = 1'b1; ewe = we[g]; ead = ad[g]; ewd = wd[g]; end
        erv = '0; erd = 1'b0;
        if (m_pend >= 0 && !rst_i) begin erv[m_pend] = 1'b1; erd = m_pdata; end
        ebusy = (m_pend >= 0) || m_lock;
        chk("req_ready", req_ready_o, eg);
        chk("vt_en", vt_en_o, g >= 0);
        chk("vt_we", vt_we_o, ewe);
        chk("vt_addr", vt_addr_o, ead);
        chk("vt_wdata", vt_wdata_o, ewd);
        chk("rsp_valid", rsp_valid_o, erv);
        chk("rsp_data", rsp_data_o, erd);
        chk("busy", busy_o, ebusy);
        last_gnt = req_ready_o; last_rvld = rsp_valid_o; last_rdata = rsp_data_o;
        if (g >= 0 && we[g]) ref_mem[ad[g]] = wd[g];
        m_pend = -1;
        if (rst_i) begin
            m_ptr = 0; m_lock = 0; m_own = 0;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % N; m_lock = lk[g]; m_own = g;
            if (!we[g]) begin m_pend = g; m_pdata = ref_mem[ad[g]]; end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); rst_i = 1'b1; cyc(); rst_i = 1'b0;
    endtask

    logic [N-1:0] exp_seq [6];
    logic orig, flip;

    initial begin
        idle();
        ram_seed = DEPTH'($urandom);
        ref_mem  = ram_seed;
        ram_load = 1'b1;
        rst_i    = 1'b1;
        req_valid_i = '0; req_we_i = '0; req_lock_i = '0; req_addr_i = '0; req_wdata_i = '0;
        @(posedge clk); #1;
        ram_load = 1'b0;
        m_ptr = 0; m_own = 0; m_pend = -1; m_lock = 0; m_pdata = 1'b0;
        do_reset();

        // Reset state and single read
        idle(); cyc();
        v = 3'b001; ad[0] = 4'd2; cyc();
        chk("t1_grant", last_gnt, 3'b001);
        idle(); cyc();
        chk("t1_rsp", last_rvld, 3'b001);
        cyc();

        // All three cores hold reads
        do_reset();
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        v = 3'b111; ad[0] = 4'd1; ad[1] = 4'd5; ad[2] = 4'd9;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t2_order", last_gnt, exp_seq[i]);
        end
        idle(); cyc(); cyc();

        // Locked read-modify-write flip
        do_reset();
        orig = ref_mem[4]; flip = ~orig;
        v = 3'b110; lk[1] = 1'b1; ad[1] = 4'd4; ad[2] = 4'd7; cyc();
        chk("t3_rd", last_gnt, 3'b010);
        lk = '0; we[1] = 1'b1; wd[1] = flip; cyc();
        chk("t3_wr", last_gnt, 3'b010);
        v = 3'b100; we = '0; cyc();
        chk("t3_core2", last_gnt, 3'b100);
        idle(); v = 3'b001; ad[0] = 4'd4; cyc();
        idle(); cyc();
        chk("t3_readback", last_rdata, flip);
        cyc();

        // Idle lock owner starves others
        do_reset();
        v = 3'b011; lk[0] = 1'b1; ad[0] = 4'd3; ad[1] = 4'd6; cyc();
        chk("t4_lock", last_gnt, 3'b001);
        lk = '0; v = 3'b010;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_starve", last_gnt, 3'b000);
        end
        v = 3'b011; cyc();
        chk("t4_owner", last_gnt, 3'b001);
        cyc();
        chk("t4_next", last_gnt, 3'b010);
        idle(); cyc(); cyc();

        // Pause with a read in flight
        do_reset();
        v = 3'b001; ad[0] = 4'd2; cyc();
        pause_i = 1'b1; v = 3'b111;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t5_pause", last_gnt, 3'b000);
            if (i == 0) chk("t5_rsp", last_rvld, 3'b001);
        end
        pause_i = 1'b0; cyc();
        chk("t5_resume", last_gnt, 3'b010);
        idle(); cyc(); cyc();

        // Reset kills an in-flight read
        do_reset();
        v = 3'b010; ad[1] = 4'd8; cyc();
        v = 3'b001; ad[0] = 4'd8; cyc();
        idle(); rst_i = 1'b1; cyc();
        chk("t6_norsp", last_rvld, 3'b000);
        rst_i = 1'b0; v = 3'b111; cyc();
        chk("t6_first", last_gnt, 3'b001);
        idle(); cyc(); cyc();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            v       = N'($urandom);
            we      = N'($urandom);
            lk      = N'($urandom) & N'($urandom);
            pause_i = ($urandom_range(7) == 0);
            rst_i   = ($urandom_range(49) == 0);
            for (int i = 0; i < N; i++) begin
                ad[i] = AW'($urandom);
                wd[i] = 1'($urandom);
            end
            cyc();
        end
        idle(); cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
